// File: rtl/rr_encoder_arbiter_if.sv
// Request/grant bundle between the requesting units and the round-robin arbiter.
// Requesters drive through master; the arbiter attaches through slave.
interface rr_encoder_arbiter_if #(
  parameter int N     = 4,
  parameter int IDX_W = 2
);
  logic [N-1:0]     req;
  logic             done;
  logic [N-1:0]     grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  grant, grant_idx, grant_valid, timeout
  );

  modport slave (
    input  req, done,
    output grant, grant_idx, grant_valid, timeout
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// Four-way round-robin arbiter with one-hot and encoded grant, hold-time limit,
// and a mandatory idle cycle between owners. All outputs are registered.
module rr_encoder_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  rr_encoder_arbiter_if.slave   io_arb
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_GRANT = 1'b1} state_t;

  state_t           r_state;
  logic [N-1:0]     r_grant;
  logic [IDX_W-1:0] r_idx;
  logic             r_valid;
  logic             r_timeout;
  logic [CNT_W-1:0] r_hold;
  logic [IDX_W-1:0] r_last;

  state_t           w_state;
  logic [N-1:0]     w_grant;
  logic [IDX_W-1:0] w_idx;
  logic             w_valid;
  logic             w_timeout;
  logic [CNT_W-1:0] w_hold;
  logic [IDX_W-1:0] w_last;
  logic [IDX_W:0]   w_pick;
  logic             w_rel_done;
  logic             w_rel_drop;
  logic             w_rel_hold;

  // Returns {found, index} of the first set request after last, scanning with wrap.
  // Scanning from the farthest position down lets the closest hit overwrite earlier ones.
  function automatic logic [IDX_W:0] rr_pick(input logic [N-1:0] req,
                                             input logic [IDX_W-1:0] last);
    logic [IDX_W:0]   res;
    logic [IDX_W-1:0] pos;
    res = {(IDX_W+1){1'b0}};
    for (int i = N; i >= 1; i--) begin
      pos = IDX_W'((int'(last) + i) % N);
      res = req[pos] ? {1'b1, pos} : res;
    end
    return res;
  endfunction

  // Next-state and next-output decode for the IDLE/GRANT machine.
  always_comb begin
    w_state    = r_state;
    w_grant    = r_grant;
    w_idx      = r_idx;
    w_valid    = r_valid;
    w_timeout  = 1'b0;
    w_hold     = r_hold;
    w_last     = r_last;
    w_pick     = rr_pick(io_arb.req, r_last);
    w_rel_done = io_arb.done;
    w_rel_drop = ~io_arb.req[r_idx];
    w_rel_hold = (r_hold == CNT_W'(MAX_HOLD - 1));

    case (r_state)
      ST_IDLE: begin
        if (w_pick[IDX_W]) begin
          w_state = ST_GRANT;
          w_grant = N'(1'b1) << w_pick[IDX_W-1:0];
          w_idx   = w_pick[IDX_W-1:0];
          w_valid = 1'b1;
          w_hold  = {CNT_W{1'b0}};
        end else begin
          w_grant = {N{1'b0}};
          w_idx   = {IDX_W{1'b0}};
          w_valid = 1'b0;
          w_hold  = {CNT_W{1'b0}};
        end
      end
      ST_GRANT: begin
        if (w_rel_done || w_rel_drop || w_rel_hold) begin
          w_state   = ST_IDLE;
          w_grant   = {N{1'b0}};
          w_idx     = {IDX_W{1'b0}};
          w_valid   = 1'b0;
          w_hold    = {CNT_W{1'b0}};
          w_last    = r_idx;
          // Timeout flags only a release the owner did not ask for itself.
          w_timeout = w_rel_hold & ~w_rel_done & ~w_rel_drop;
        end else begin
          w_hold = r_hold + CNT_W'(1);
        end
      end
      default: begin
        w_state = ST_IDLE;
        w_grant = {N{1'b0}};
        w_idx   = {IDX_W{1'b0}};
        w_valid = 1'b0;
        w_hold  = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and output registers; last_ptr resets to N-1 so requester 0 wins first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_grant   <= {N{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_hold    <= {CNT_W{1'b0}};
      r_last    <= IDX_W'(N - 1);
    end else begin
      r_state   <= w_state;
      r_grant   <= w_grant;
      r_idx     <= w_idx;
      r_valid   <= w_valid;
      r_timeout <= w_timeout;
      r_hold    <= w_hold;
      r_last    <= w_last;
    end
  end

  assign io_arb.grant       = r_grant;
  assign io_arb.grant_idx   = r_idx;
  assign io_arb.grant_valid = r_valid;
  assign io_arb.timeout     = r_timeout;

endmodule

// File: tb/tb_rr_encoder_arbiter.sv
// Directed bench for rr_encoder_arbiter: hand-computed grant sequences plus
// per-cycle output invariants sampled on the falling edge.
module tb_rr_encoder_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic prev_to  = 1'b0;

  rr_encoder_arbiter_if #(.N(4), .IDX_W(2)) u_if ();

  rr_encoder_arbiter #(
    .N(4), .IDX_W(2), .MAX_HOLD(8), .CNT_W(8)
  ) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_arb(u_if)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_out(input string tag, input logic [3:0] g, input logic [1:0] idx,
                            input logic v, input logic to);
    check_value({tag, ".grant"},   32'(u_if.grant),       32'(g));
    check_value({tag, ".idx"},     32'(u_if.grant_idx),   32'(idx));
    check_value({tag, ".valid"},   32'(u_if.grant_valid), 32'(v));
    check_value({tag, ".timeout"}, 32'(u_if.timeout),     32'(to));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Output invariants, checked once per cycle away from the active edge.
  always @(negedge clk) begin
    check_value("inv_onehot", 32'($onehot0(u_if.grant)), 32'd1);
    check_value("inv_valid", 32'(u_if.grant_valid), 32'(|u_if.grant));
    if (u_if.grant_valid)
      check_value("inv_enc", 32'(u_if.grant), 32'(4'b0001 << u_if.grant_idx));
    else
      check_value("inv_idx_zero", 32'(u_if.grant_idx), 32'd0);
    check_value("inv_to_pulse", 32'(prev_to & u_if.timeout), 32'd0);
    prev_to <= u_if.timeout;
  end

  initial begin
    logic [1:0] exp_idx;
    u_if.req  = 4'b0000;
    u_if.done = 1'b0;
    rst       = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    expect_out("reset", 4'b0000, 2'd0, 1'b0, 1'b0);
    rst = 1'b0;

    // Single requester released by done.
    u_if.req = 4'b0001;
    step(); expect_out("t1_grant", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expect_out("t1_hold1", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expect_out("t1_hold2", 4'b0001, 2'd0, 1'b1, 1'b0);
    u_if.done = 1'b1;
    step(); expect_out("t1_done", 4'b0000, 2'd0, 1'b0, 1'b0);
    u_if.done = 1'b0;
    u_if.req  = 4'b0000;
    step(); expect_out("t1_idle", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Fair rotation with all requesters active, one bubble between owners.
    rst = 1'b1;
    step();
    rst = 1'b0;
    u_if.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_idx = 2'(k % 4);
      step(); expect_out("t2_grant", 4'(4'b0001 << exp_idx), exp_idx, 1'b1, 1'b0);
      step(); expect_out("t2_hold",  4'(4'b0001 << exp_idx), exp_idx, 1'b1, 1'b0);
      u_if.done = 1'b1;
      step(); expect_out("t2_bubble", 4'b0000, 2'd0, 1'b0, 1'b0);
      u_if.done = 1'b0;
    end

    // Hold limit: eight cycles of ownership, then a one-cycle timeout.
    u_if.req = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      step(); expect_out("t3_held", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    step(); expect_out("t3_timeout", 4'b0000, 2'd0, 1'b0, 1'b1);
    step(); expect_out("t3_regrant", 4'b0100, 2'd2, 1'b1, 1'b0);

    // done coinciding with the hold limit suppresses timeout.
    for (int k = 0; k < 7; k++) begin
      step(); expect_out("t5_held", 4'b0100, 2'd2, 1'b1, 1'b0);
    end
    u_if.done = 1'b1;
    step(); expect_out("t5_coincide", 4'b0000, 2'd0, 1'b0, 1'b0);
    u_if.done = 1'b0;

    // No pre-emption; owner drop releases; waiting requester follows after a bubble.
    u_if.req = 4'b0010;
    step(); expect_out("t4_grant1", 4'b0010, 2'd1, 1'b1, 1'b0);
    u_if.req = 4'b1010;
    step(); expect_out("t4_nopreempt_a", 4'b0010, 2'd1, 1'b1, 1'b0);
    step(); expect_out("t4_nopreempt_b", 4'b0010, 2'd1, 1'b1, 1'b0);
    u_if.req = 4'b1000;
    step(); expect_out("t4_drop", 4'b0000, 2'd0, 1'b0, 1'b0);
    step(); expect_out("t4_grant3", 4'b1000, 2'd3, 1'b1, 1'b0);
    u_if.req = 4'b0000;
    step(); expect_out("t4_release3", 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-grant, then priority restarts at requester 0.
    u_if.req = 4'b0100;
    step(); expect_out("t6_grant2", 4'b0100, 2'd2, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 expect_out("t6_async", 4'b0000, 2'd0, 1'b0, 1'b0);
    u_if.req = 4'b1111;
    #2 rst = 1'b0;
    step(); expect_out("t6_first", 4'b0001, 2'd0, 1'b1, 1'b0);
    step(); expect_out("t6_hold", 4'b0001, 2'd0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
